// File: rtl/eth_pkg.sv
// Shared definitions for the 10BASE-T transmit MAC.
//   eth_state_e    : transmitter state encoding
//   CRC_POLY/INIT  : IEEE 802.3 CRC-32 polynomial and preset value
//   SFD            : start-of-frame delimiter byte
//   PREAMBLE_BYTE  : preamble fill byte
//   manchester()   : half-bit line level for a data bit
package eth_pkg;

    typedef enum logic [2:0] {
        StLink,
        StPreamble,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIdle,
        StIpg
    } eth_state_e;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;

    // First half of a bit cell carries the inverted bit, second half the bit itself.
    function automatic logic manchester(input logic bit_val, input logic second_half);
        return second_half ? bit_val : ~bit_val;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Bit-serial CRC-32 (MSB-first shift register, data bits presented LSB first).
//   clk    in   system clock
//   rst    in   asynchronous active-high reset, presets the register
//   init   in   synchronous preset to CRC_INIT
//   enable in   shift one data bit in this clk
//   din    in   data bit
//   crc    out  current register contents (not complemented)
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        enable,
    input  logic        din,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic        feedback;

    assign feedback = crc_q[31] ^ din;
    assign crc      = crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else if (init) begin
            crc_q <= CRC_INIT;
        end else if (enable) begin
            crc_q <= {crc_q[30:0], 1'b0} ^ (feedback ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/eth_tx_mac.sv
// 10BASE-T transmit MAC: frames a payload from an internal byte buffer with preamble,
// SFD, zero padding and FCS, Manchester-encodes it onto tx, and emits normal link
// pulses while idle.
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   clk_en  in   half-bit strobe; all line activity advances only on this
//   w_addr  in   frame buffer write address
//   w_data  in   frame buffer write data
//   w_en    in   frame buffer write strobe (any clk, any state)
//   len     in   payload byte count, sampled when start is accepted
//   start   in   transmit request, accepted while busy is low
//   busy    out  high from start acceptance until return to link state
//   done    out  one-clk pulse when the inter-packet gap completes
//   tx      out  registered Manchester line output
//   tx_led  out  high while in link state
module eth_tx_mac
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W         = 11,
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned MIN_LEN        = 60,
    parameter int unsigned LINK_PERIOD    = 320000,
    parameter int unsigned IDLE_TICKS     = 6,
    parameter int unsigned IPG_TICKS      = 192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [7:0]        w_data,
    input  logic              w_en,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              tx,
    output logic              tx_led
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned TIMER_W = (LINK_PERIOD > 1) ? $clog2(LINK_PERIOD) : 1;
    // Shared byte/tick counter; wide enough for payload length, MIN_LEN and gap lengths.
    localparam int unsigned CNT_W   = 16;

    localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(LINK_PERIOD - 1);
    localparam logic [LEN_W-1:0]   LenMax    = LEN_W'(DEPTH);
    localparam logic [CNT_W-1:0]   PreLast   = CNT_W'(PREAMBLE_BYTES - 1);
    localparam logic [CNT_W-1:0]   MinLen    = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0]   IdleLast  = CNT_W'(IDLE_TICKS - 1);
    localparam logic [CNT_W-1:0]   IpgLast   = CNT_W'(IPG_TICKS - 1);

    // ------------------------------------------------------------------
    // Frame buffer: simple dual-port RAM, never reset.
    // ------------------------------------------------------------------
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] fetch_ptr;

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    // Read every clk so a late write to an address not yet loaded is still picked up.
    always_ff @(posedge clk) begin
        rd_data <= mem[fetch_ptr];
    end

    // ------------------------------------------------------------------
    // Transmit state
    // ------------------------------------------------------------------
    eth_state_e         state_q;
    logic [LEN_W-1:0]   len_q;
    logic [7:0]         byte_q;
    logic [2:0]         bit_idx;
    logic               half_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TIMER_W-1:0] timer_q;

    logic [31:0]        crc;
    logic               crc_init;
    logic               crc_en;
    logic               serial;
    logic               byte_end;
    logic               cur_bit;
    logic [4:0]         fcs_idx;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   len_cnt;
    logic [LEN_W-1:0]   len_clamped;

    always_comb begin
        serial   = 1'b0;
        unique case (state_q)
            StPreamble, StSfd, StData, StPad, StFcs: serial = 1'b1;
            default:                                 serial = 1'b0;
        endcase
        byte_end = half_q & (bit_idx == 3'd7);
        // FCS wire bit n is bit (31 - n) of the complemented register.
        fcs_idx  = {cnt_q[1:0], bit_idx};
        cur_bit  = (state_q == StFcs) ? ~crc[~fcs_idx] : byte_q[bit_idx];
        cnt_inc  = cnt_q + 1'b1;
        len_cnt  = CNT_W'(len_q);
        len_clamped = (len > LenMax) ? LenMax : len;
        crc_init = clk_en & busy & (state_q == StLink);
        // Each payload bit enters the CRC on the tick that sends its second half.
        crc_en   = clk_en & half_q & ((state_q == StData) | (state_q == StPad));
    end

    eth_crc32 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (crc_init),
        .enable (crc_en),
        .din    (cur_bit),
        .crc    (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLink;
            tx        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_led    <= 1'b1;
            timer_q   <= '0;
            len_q     <= '0;
            fetch_ptr <= '0;
            byte_q    <= '0;
            bit_idx   <= '0;
            half_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done <= 1'b0;

            // Acceptance is the only event not gated by clk_en.
            if (start && !busy) begin
                busy  <= 1'b1;
                len_q <= len_clamped;
            end

            if (clk_en) begin
                timer_q <= (timer_q == TimerLast) ? '0 : timer_q + 1'b1;

                if (serial) begin
                    tx     <= manchester(cur_bit, half_q);
                    half_q <= ~half_q;
                    if (half_q) begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end

                unique case (state_q)
                    StLink: begin
                        if (busy) begin
                            // First preamble half-bit goes out on the entry tick.
                            state_q   <= StPreamble;
                            tx        <= manchester(PREAMBLE_BYTE[0], 1'b0);
                            tx_led    <= 1'b0;
                            byte_q    <= PREAMBLE_BYTE;
                            bit_idx   <= '0;
                            half_q    <= 1'b1;
                            cnt_q     <= '0;
                            fetch_ptr <= '0;
                        end else begin
                            tx <= (timer_q == '0);
                        end
                    end

                    StPreamble: begin
                        if (byte_end) begin
                            if (cnt_q == PreLast) begin
                                state_q <= StSfd;
                                byte_q  <= SFD;
                                cnt_q   <= '0;
                            end else begin
                                byte_q <= PREAMBLE_BYTE;
                                cnt_q  <= cnt_inc;
                            end
                        end
                    end

                    StSfd: begin
                        if (byte_end) begin
                            cnt_q <= '0;
                            if (len_q != '0) begin
                                state_q   <= StData;
                                byte_q    <= rd_data;
                                fetch_ptr <= fetch_ptr + 1'b1;
                            end else if (MinLen != '0) begin
                                state_q <= StPad;
                                byte_q  <= 8'h00;
                            end else begin
                                state_q <= StFcs;
                            end
                        end
                    end

                    StData: begin
                        if (byte_end) begin
                            if (cnt_inc < len_cnt) begin
                                byte_q    <= rd_data;
                                fetch_ptr <= fetch_ptr + 1'b1;
                                cnt_q     <= cnt_inc;
                            end else if (cnt_inc < MinLen) begin
                                state_q <= StPad;
                                byte_q  <= 8'h00;
                                cnt_q   <= cnt_inc;
                            end else begin
                                state_q <= StFcs;
                                cnt_q   <= '0;
                            end
                        end
                    end

                    StPad: begin
                        if (byte_end) begin
                            if (cnt_inc < MinLen) begin
                                cnt_q <= cnt_inc;
                            end else begin
                                state_q <= StFcs;
                                cnt_q   <= '0;
                            end
                        end
                    end

                    StFcs: begin
                        if (byte_end) begin
                            if (cnt_q[1:0] == 2'd3) begin
                                state_q <= StIdle;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end

                    StIdle: begin
                        tx <= 1'b1;
                        if (cnt_q == IdleLast) begin
                            state_q <= StIpg;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end

                    StIpg: begin
                        tx <= 1'b0;
                        if (cnt_q == IpgLast) begin
                            state_q <= StLink;
                            tx_led  <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/eth_tx_mac.md
ETH_TX_MAC -- requirements
Module: eth_tx_mac

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, frame buffer address width (depth 2^ADDR_W bytes).
REQ-002 SHALL have parameter PREAMBLE_BYTES, default 7, number of 0x55 bytes before the SFD.
REQ-003 SHALL have parameter MIN_LEN, default 60, minimum payload bytes before the FCS; shorter frames are zero-padded.
REQ-004 SHALL have parameter LINK_PERIOD, default 320000, clk_en ticks between normal link pulses.
REQ-005 SHALL have parameters IDLE_TICKS, default 6, and IPG_TICKS, default 192, the TP_IDL-high and inter-packet-gap lengths in clk_en ticks.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  system clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 clk_en  in  1  half-bit strobe at 20 MHz equivalent; all line activity advances only on clk_en.
REQ-010 w_addr  in  ADDR_W  frame buffer write address.
REQ-011 w_data  in  8  frame buffer write data.
REQ-012 w_en  in  1  buffer write strobe, honoured on every clk, independent of clk_en and state.
REQ-013 len  in  ADDR_W+1  payload byte count, sampled when start is accepted.
REQ-014 start  in  1  transmit request.
REQ-015 busy  out  1  high from start acceptance until return to LINK.
REQ-016 done  out  1  one-clk pulse when a frame's IPG completes.
REQ-017 tx  out  1  registered Manchester line output.
REQ-018 tx_led  out  1  high while in LINK.

Function
REQ-019 SHALL implement states LINK, PREAMBLE, SFD, DATA, PAD, FCS, IDLE, IPG.
REQ-020 start SHALL be accepted on any clk with busy=0; busy rises the next clk; PREAMBLE starts on the next clk_en tick; start while busy=1 SHALL be ignored.
REQ-021 len SHALL be latched at acceptance; len > 2^ADDR_W clamps to 2^ADDR_W; len=0 sends only padding.
REQ-022 Bytes SHALL be sent LSB first, two ticks per bit: first half !bit, second half bit.
REQ-023 PREAMBLE sends PREAMBLE_BYTES x 0x55, SFD sends 0xD5, DATA sends buffer[0..len-1], PAD sends max(0, MIN_LEN-len) zero bytes, FCS sends 4 bytes.
REQ-024 Buffer bytes SHALL be fetched one byte ahead with no gap between bytes; a write to an address not yet fetched is transmitted.
REQ-025 CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, data fed LSB first) SHALL cover DATA and PAD bytes; FCS SHALL be the complemented register, giving standard CRC-32 bytes LSB first on the wire.
REQ-026 After FCS: IDLE holds tx=1 for IDLE_TICKS ticks, IPG holds tx=0 for IPG_TICKS ticks, then LINK with done pulsed and busy cleared the same clk.
REQ-027 Link timer SHALL free-run 0..LINK_PERIOD-1 on clk_en in all states; in LINK tx=1 for exactly the tick where timer=0, else 0.
REQ-028 State transitions SHALL occur only on clk_en ticks, except start acceptance.

Reset
REQ-029 rst SHALL force state=LINK, tx=0, busy=0, done=0, tx_led=1, link timer=0, CRC=0xFFFFFFFF, immediately, including mid-frame.
REQ-030 Frame buffer contents SHALL NOT be reset.

Structure
REQ-031 Package eth_pkg SHALL hold the state enum, CRC_POLY, CRC_INIT, SFD (0xD5) and PREAMBLE_BYTE (0x55) constants.
REQ-032 Bit-serial CRC SHALL be sub-module eth_crc32 (init, enable, bit in, 32-bit out).
REQ-033 Frame buffer SHALL be inferred as a simple dual-port RAM (write port w_*, read port from the fetch pointer).

Verification
REQ-034 Buffer "123456789", len=9, MIN_LEN=0 -> decoded wire: 7x55, D5, 31..39, FCS 26 39 F4 CB.
REQ-035 len=10, MIN_LEN=60 -> 10 data + 50 zero bytes, FCS over 60 bytes, total 72 bytes after decoding.
REQ-036 Idle, clk_en every clk -> tx pulses one tick every 320000 ticks; tx_led=1 throughout.
REQ-037 start pulsed twice, second during DATA -> one frame, one done pulse, busy high PREAMBLE through IPG.
REQ-038 rst asserted during DATA byte 5 -> tx=0, busy=0 same cycle; next start sends full correct frame.
